// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM field constants, block/state types and the x-multiply helper
package gcm_pkg;

    localparam int DATA_WIDTH  = 128;
    localparam int SPLIT_WIDTH = 32;
    localparam int N_SLICES    = DATA_WIDTH / SPLIT_WIDTH;
    localparam int K_WIDTH     = $clog2(N_SLICES);

    localparam logic [DATA_WIDTH-1:0] GCM_R = {8'hE1, 120'h0};

    typedef logic [DATA_WIDTH-1:0] gcm_blk_t;

    typedef enum logic [1:0] {IDLE, MUL, DONE} ghash_state_e;

    // One multiply-by-x in GCM's reflected bit order: right shift, reduce on carry-out
    function automatic gcm_blk_t gf_mul_x(input gcm_blk_t v);
        return (v >> 1) ^ (v[0] ? GCM_R : '0);
    endfunction

endpackage

// File: rtl/ghash_accum_if.sv
// ghash_accum_if: block-in / tag-out handshake and H/start controls (GHASH_TAG_MASK_EN adds ek0_i)
interface ghash_accum_if;
    import gcm_pkg::*;

    gcm_blk_t h_i;
    logic     h_load_i;
    logic     start_i;
    logic     blk_valid_i;
    logic     blk_ready_o;
    gcm_blk_t blk_i;
    logic     blk_last_i;
    logic     tag_valid_o;
    logic     tag_ready_i;
    gcm_blk_t tag_o;
    logic     busy_o;
`ifdef GHASH_TAG_MASK_EN
    gcm_blk_t ek0_i;
`endif

    modport slave (
        input  h_i, h_load_i, start_i, blk_valid_i, blk_i, blk_last_i, tag_ready_i,
`ifdef GHASH_TAG_MASK_EN
        input  ek0_i,
`endif
        output blk_ready_o, tag_valid_o, tag_o, busy_o
    );

    modport master (
        output h_i, h_load_i, start_i, blk_valid_i, blk_i, blk_last_i, tag_ready_i,
`ifdef GHASH_TAG_MASK_EN
        output ek0_i,
`endif
        input  blk_ready_o, tag_valid_o, tag_o, busy_o
    );

endinterface

// File: rtl/ghash_slice_step.sv
// ghash_slice_step: 32 shift-and-add steps of a GF(2^128) multiply against one slice of H
module ghash_slice_step
    import gcm_pkg::*;
(
    input  gcm_blk_t               a_i,
    input  logic [SPLIT_WIDTH-1:0] h_slice_i,
    output gcm_blk_t               pp_o,
    output gcm_blk_t               ax_o
);

    gcm_blk_t v;

    // Slice MSB pairs with a itself; each following bit pairs with one more factor of x
    always_comb begin
        v    = a_i;
        pp_o = '0;
        for (int j = 0; j < SPLIT_WIDTH; j++) begin
            pp_o = pp_o ^ (h_slice_i[SPLIT_WIDTH-1-j] ? v : '0);
            v    = gf_mul_x(v);
        end
        ax_o = v;
    end

endmodule

// File: rtl/ghash_accum.sv
// ghash_accum: iterative GHASH, 4 cycles per block; GHASH_TAG_MASK_EN masks the tag with ek0_i
module ghash_accum
    import gcm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    ghash_accum_if.slave bus
);

    ghash_state_e         state_q, state_d;
    logic [K_WIDTH-1:0]   k_q, k_d;
    gcm_blk_t             y_q, y_d;
    gcm_blk_t             h_q, h_d;
    gcm_blk_t             acc_q, acc_d;
    gcm_blk_t             a_q, a_d;
    gcm_blk_t             tag_q, tag_d;
    logic                 last_q, last_d;
    logic [SPLIT_WIDTH-1:0] h_slice;
    gcm_blk_t             pp, ax;
    gcm_blk_t             y_new;
    gcm_blk_t             tag_mask;

`ifdef GHASH_TAG_MASK_EN
    assign tag_mask = bus.ek0_i;
`else
    assign tag_mask = '0;
`endif

    // Slice 0 is the top 32 bits of H, i.e. GCM bits 0..31
    assign h_slice = h_q[DATA_WIDTH-1-SPLIT_WIDTH*int'(k_q) -: SPLIT_WIDTH];
    assign y_new   = acc_q ^ pp;

    ghash_slice_step u_step (
        .a_i       (a_q),
        .h_slice_i (h_slice),
        .pp_o      (pp),
        .ax_o      (ax)
    );

    assign bus.blk_ready_o = (state_q == IDLE);
    assign bus.tag_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.tag_o       = tag_q;

    // Next-state: accept in IDLE, accumulate one slice per MUL cycle, hold tag in DONE
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        y_d     = y_q;
        h_d     = h_q;
        acc_d   = acc_q;
        a_d     = a_q;
        tag_d   = tag_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                h_d = bus.h_load_i ? bus.h_i : h_q;
                y_d = bus.start_i ? '0 : y_q;
                if (bus.blk_valid_i) begin
                    a_d     = (bus.start_i ? '0 : y_q) ^ bus.blk_i;
                    acc_d   = '0;
                    k_d     = '0;
                    last_d  = bus.blk_last_i;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = y_new;
                a_d   = ax;
                k_d   = k_q + 1'b1;
                if (k_q == K_WIDTH'(N_SLICES - 1)) begin
                    y_d     = y_new;
                    tag_d   = last_q ? (y_new ^ tag_mask) : tag_q;
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (bus.tag_ready_i) begin
                    y_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            y_q     <= '0;
            h_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            tag_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            y_q     <= y_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_ghash_accum.sv
// tb_ghash_accum: known-answer and randomized checks of ghash_accum against a textbook GF(2^128) model
module tb_ghash_accum;
    import gcm_pkg::*;

    localparam logic [127:0] R_POLY = 128'hE1000000_00000000_00000000_00000000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run = 0;
    int   n_fail = 0;

    ghash_accum_if bus();

    ghash_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    gcm_blk_t y_m;
    gcm_blk_t h_m;
    gcm_blk_t ek0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GCM multiply, bit-serial over X from GCM bit 0 (MSB) to bit 127
    function automatic gcm_blk_t gmul(input gcm_blk_t x, input gcm_blk_t y);
        gcm_blk_t z = '0;
        gcm_blk_t v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        end
        return z;
    endfunction

    function automatic gcm_blk_t tagx(input gcm_blk_t y);
`ifdef GHASH_TAG_MASK_EN
        return y ^ ek0;
`else
        return y;
`endif
    endfunction

    task automatic set_ek0(input gcm_blk_t e);
        ek0 = e;
`ifdef GHASH_TAG_MASK_EN
        bus.ek0_i = e;
`endif
    endtask

    task automatic load_h(input gcm_blk_t h);
        bus.h_i = h;
        bus.h_load_i = 1'b1;
        @(negedge clk);
        bus.h_load_i = 1'b0;
        h_m = h;
    endtask

    // Called at a negedge; returns at the negedge where the multiply has finished
    task automatic send(input gcm_blk_t x, input logic last, input logic st);
        int n = 0;
        bus.blk_i = x;
        bus.blk_last_i = last;
        bus.start_i = st;
        bus.blk_valid_i = 1'b1;
        while (!bus.blk_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 128'(bus.blk_ready_o), 128'd1);
        @(posedge clk);
        @(negedge clk);
        bus.blk_valid_i = 1'b0;
        bus.blk_i = ~x;
        bus.h_i = ~h_m;
        bus.h_load_i = 1'b1;
        bus.start_i = 1'b1;
        if (st) y_m = '0;
        y_m = gmul(y_m ^ x, h_m);
        n = 0;
        while (!bus.blk_ready_o && !bus.tag_valid_o && n < 10) begin
            n++;
            @(negedge clk);
        end
        bus.h_load_i = 1'b0;
        bus.start_i = 1'b0;
        bus.h_i = h_m;
        chk("busy_cycles", 128'(n), 128'd4);
        chk(last ? "tag_up" : "ready_back", 128'(last ? bus.tag_valid_o : bus.blk_ready_o), 128'd1);
    endtask

    task automatic get_tag(input string tag, input gcm_blk_t exp, input int hold);
        chk({tag, "_valid"}, 128'(bus.tag_valid_o), 128'd1);
        chk(tag, bus.tag_o, exp);
        if (hold > 0) begin
            bus.blk_i = ~exp;
            bus.blk_last_i = 1'b0;
            bus.blk_valid_i = 1'b1;
            repeat (hold) @(negedge clk);
            chk({tag, "_hold"}, bus.tag_o, exp);
            chk({tag, "_hold_valid"}, 128'(bus.tag_valid_o), 128'd1);
            chk({tag, "_hold_noacc"}, 128'({bus.blk_ready_o, bus.busy_o}), 128'b01);
            bus.blk_valid_i = 1'b0;
        end
        bus.tag_ready_i = 1'b1;
        @(negedge clk);
        bus.tag_ready_i = 1'b0;
        chk({tag, "_release"}, 128'({bus.tag_valid_o, bus.blk_ready_o}), 128'b01);
        y_m = '0;
    endtask

    task automatic vector_run(input string tag);
        gcm_blk_t exp;
`ifdef GHASH_TAG_MASK_EN
        exp = 128'hab6e47d42cec13bdf53a67b21257bddf;
`else
        exp = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
`endif
        set_ek0(128'h58e2fccefa7e3061367f1d57a4e7455a);
        load_h(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        send(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, 1'b1);
        send(128'h00000000000000000000000000000080, 1'b1, 1'b0);
        get_tag(tag, exp, 10);
    endtask

    initial begin
        gcm_blk_t a, b, x;
        int nb;
        rst_n = 1'b0;
        y_m = '0;
        h_m = '0;
        bus.h_i = '0;
        bus.h_load_i = 1'b0;
        bus.start_i = 1'b0;
        bus.blk_valid_i = 1'b0;
        bus.blk_i = '0;
        bus.blk_last_i = 1'b0;
        bus.tag_ready_i = 1'b0;
        set_ek0('0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(bus.blk_ready_o), 128'd1);
        chk("rst_flags", 128'({bus.tag_valid_o, bus.busy_o}), 128'd0);
        chk("rst_tag", bus.tag_o, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        vector_run("tc2_tag");

        set_ek0(128'h0f0e0d0c0b0a09080706050403020100);
        load_h(128'h80000000000000000000000000000000);
        x = 128'h0123456789abcdef0011223344556677;
        send(x, 1'b1, 1'b1);
        get_tag("one_tag", tagx(x), 0);

        load_h('0);
        send('1, 1'b0, 1'b1);
        send('1, 1'b0, 1'b0);
        send('1, 1'b1, 1'b0);
        get_tag("zero_h_tag", tagx('0), 2);

        load_h({$urandom, $urandom, $urandom, $urandom});
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        send(a, 1'b0, 1'b1);
        send(b, 1'b1, 1'b1);
        get_tag("start_wins", tagx(gmul(b, h_m)), 0);

        for (int t = 0; t < 8; t++) begin
            set_ek0({$urandom, $urandom, $urandom, $urandom});
            load_h({$urandom, $urandom, $urandom, $urandom});
            nb = int'($urandom_range(1, 4));
            for (int i = 0; i < nb; i++)
                send({$urandom, $urandom, $urandom, $urandom}, i == nb - 1, i == 0);
            get_tag("rand_tag", tagx(y_m), int'($urandom_range(0, 3)));
        end

        load_h(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        bus.blk_i = 128'h0388dace60b6a392f328c2b971b2fe78;
        bus.blk_last_i = 1'b1;
        bus.start_i = 1'b1;
        bus.blk_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.blk_valid_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 128'(bus.blk_ready_o), 128'd1);
        chk("abort_flags", 128'({bus.tag_valid_o, bus.busy_o}), 128'd0);
        chk("abort_tag", bus.tag_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        y_m = '0;
        h_m = '0;
        repeat (6) @(negedge clk);
        chk("abort_no_tag", 128'(bus.tag_valid_o), 128'd0);
        vector_run("rerun_tag");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_run);
        $fatal(1);
    end

endmodule

// File: doc/ghash_accum.md
# ghash_accum

Iterative GHASH accumulator for the AES-GCM datapath. It consumes 128-bit AAD, ciphertext and length blocks and computes Y_i = (Y_{i-1} ⊕ X_i)·H in GF(2^128). Each multiply takes four cycles, one 32-bit slice of H per cycle. On the last block it presents the authentication tag to the tag-compare/output stage.

## Interface
- DATA_WIDTH, 128, block and field width
- SPLIT_WIDTH, 32, H bits consumed per multiply cycle; DATA_WIDTH/SPLIT_WIDTH = 4 slices
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- h_i  input  128  hash subkey H = E(K,0^128)
- h_load_i  input  1  capture h_i; honoured only in IDLE
- start_i  input  1  clear Y to 0; honoured in IDLE only
- blk_valid_i  input  1  blk_i/blk_last_i valid
- blk_ready_o  output  1  block accepted when valid && ready
- blk_i  input  128  block X_i, GCM bit 0 = blk_i[127]
- blk_last_i  input  1  X_i is the final (length) block
- tag_valid_o  output  1  tag_o valid, held until accepted
- tag_ready_i  input  1  downstream accepts tag
- tag_o  output  128  GHASH result (see Configuration)
- busy_o  output  1  state != IDLE

## Operation
- FSM states:
  - IDLE: blk_ready_o=1.
  - MUL: 2-bit slice counter k=0..3.
  - DONE: tag_valid_o=1.
- IDLE, on accept: a_reg ← Y ⊕ blk_i, acc ← 0, k ← 0, last_reg ← blk_last_i, go to MUL.
- Slice k: for j=0..31, V = a_reg·x^j; acc ^= V wherever H bit (127−32k−j) is 1.
- Multiply by x: right shift by 1; if the shifted-out LSB was 1, XOR 128'hE1000000_00000000_00000000_00000000.
- Each MUL cycle: acc ← acc ⊕ slice; a_reg ← a_reg·x^32; k ← k+1.
- k=3:
  - Y ← acc ⊕ slice3.
  - If last_reg: tag_reg ← new Y, go to DONE.
  - Else: go to IDLE.
- DONE, when tag_ready_i=1: Y ← 0, go to IDLE.
- IDLE, start_i together with an accepted block: the clear wins, so a_reg ← blk_i (Y treated as 0).
- h_load_i outside IDLE is ignored; H must stay stable during MUL.
- start_i outside IDLE is ignored.
- blk_valid_i while not ready is held by upstream; blk_i may change only after acceptance.
- Reset values: all outputs 0 except blk_ready_o=1. Y, H, acc, a_reg and tag_reg are 0; state is IDLE.
- Reset mid-MUL or mid-DONE aborts the operation; no tag is emitted.

## Timing
- Accept at edge T, Y valid after edge T+4; next accept no earlier than edge T+5 (1 block / 5 cycles).
- tag_valid_o rises the cycle after the k=3 edge and stays high until tag_ready_i is sampled high.
- tag_o is registered and stable while tag_valid_o=1.
- No combinational path from blk_valid_i or tag_ready_i to any output.

## Configuration
- GHASH_TAG_MASK_EN defined:
  - Adds input ek0_i [127:0], E(K,J0).
  - tag_o = Y ⊕ ek0_i, registered at the k=3 edge; ek0_i must be valid by then.
  - Output is the final GCM tag.
- Not defined: no ek0_i port; tag_o = raw GHASH Y.

## Structure
- Shared package gcm_pkg holds:
  - GCM_R = 128'hE1 followed by 120 zero bits.
  - typedef gcm_blk_t (logic [127:0]).
  - typedef ghash_state_e {IDLE, MUL, DONE}.
  - Function gf_mul_x (one reduction shift).
- Sub-module ghash_slice_step (combinational):
  - Inputs: a [127:0], h_slice [31:0].
  - Outputs: partial product [127:0] and a·x^32 [127:0].
  - Instantiated once and reused every MUL cycle.

## Test plan
- H=66e94bd4ef8a2c3b884cfa59ca342b2e, start, blocks 0388dace60b6a392f328c2b971b2fe78 then 0…0080 (last) -> tag_o=f38cbb1ad69223dcc3457ae5b6b0f885; with mask and ek0=58e2fccefa7e3061367f1d57a4e7455a -> ab6e47d42cec13bdf53a67b21257bddf.
- H=8000…0 (field one), single last block X=0123456789abcdef0011223344556677 -> tag_o=X.
- H=0, three blocks of all-ones -> tag_o=0.
- Check blk_ready_o low for exactly 4 cycles after each accept; hold tag_ready_i=0 for 10 cycles -> tag_o stable, no block accepted.
- start_i and blk_valid_i in the same IDLE cycle after a prior non-last block -> result equals the single-block result on a fresh Y.
- Assert rst_n in cycle 2 of MUL -> all outputs reset immediately; a subsequent clean run matches the first test.
